// File: rtl/enc_pkg.sv
// Shared definitions for the enc encoder layers: controller states,
// default fixed-point format and its representable range.
package enc_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FINAL = 2'd1,
    ST_OUT   = 2'd2
  } mac_state_e;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_BITS_DEF  = 8;

  // Range of a signed DATA_WIDTH_DEF-bit Q word.
  localparam logic signed [DATA_WIDTH_DEF-1:0] Q_MAX = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
  localparam logic signed [DATA_WIDTH_DEF-1:0] Q_MIN = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/fx_round_sat.sv
// Combinational fixed-point narrowing: round-half-up, arithmetic shift by
// FRAC_BITS, saturate to a signed DATA_WIDTH word, optional ReLU clamp.
// Shared by the enc layers; the caller folds any bias into val_i first.
module fx_round_sat #(
  parameter int ACC_WIDTH  = 40,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter bit RELU       = 1'b1
) (
  input  logic signed [ACC_WIDTH-1:0]  val_i,
  output logic signed [DATA_WIDTH-1:0] res_o
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int SW = ACC_WIDTH + 1;
  localparam logic signed [SW-1:0] HALF  = SW'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [SW-1:0] MAX_V = (SW'(1) <<< (DATA_WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MIN_V = -(SW'(1) <<< (DATA_WIDTH - 1));

  logic signed [SW-1:0] sum_w;
  logic signed [SW-1:0] shr_w;

  assign sum_w = SW'(val_i) + HALF;
  assign shr_w = sum_w >>> FRAC_BITS;

  // Clamp to the output range, then optionally zero negatives.
  always_comb begin
    if (shr_w > MAX_V) begin
      res_o = MAX_V[DATA_WIDTH-1:0];
    end else if (shr_w < MIN_V) begin
      res_o = MIN_V[DATA_WIDTH-1:0];
    end else begin
      res_o = shr_w[DATA_WIDTH-1:0];
    end
    if (RELU && res_o[DATA_WIDTH-1]) begin
      res_o = '0;
    end
  end

endmodule

// File: rtl/enc2_neuron_mac.sv
// Streaming MAC neuron for the enc2 encoder: one activation per handshake,
// multiply by the matching weight, then bias/round/saturate/ReLU and emit
// one result through a valid/ready output.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_ACCUM | accepting activations, accumulating products
// ST_FINAL | one cycle: bias, round, saturate, register result
// ST_OUT   | result held on out_data until downstream takes it
module enc2_neuron_mac
  import enc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int N_IN       = 16,
  parameter int ACC_WIDTH  = 40,
  parameter bit RELU       = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN*DATA_WIDTH-1:0] weights,
  input  logic [DATA_WIDTH-1:0]      bias,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

  mac_state_e state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;

  logic signed [DATA_WIDTH-1:0]   w_sel;
  logic signed [DATA_WIDTH-1:0]   x_s;
  logic signed [DATA_WIDTH-1:0]   bias_s;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    fin_val;
  logic signed [DATA_WIDTH-1:0]   res;

  assign w_sel  = $signed(weights[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH]);
  assign x_s    = $signed(in_data);
  assign bias_s = $signed(bias);
  assign prod   = x_s * w_sel;
  // Bias is aligned to the product's 2*FRAC_BITS scale before narrowing.
  assign fin_val = acc_q + (ACC_WIDTH'(bias_s) <<< FRAC_BITS);

  fx_round_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .RELU       (RELU)
  ) u_round_sat (
    .val_i (fin_val),
    .res_o (res)
  );

  // Held low during reset so nothing upstream sees a handshake mid-reset.
  assign in_ready  = (state_q == ST_ACCUM) && !rst;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // Next-state, datapath and output register updates.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + ACC_WIDTH'(prod);
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_FINAL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_FINAL: begin
        out_data_d  = res;
        out_valid_d = 1'b1;
        acc_d       = '0;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      idx_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_enc2_neuron_mac.sv
// Directed bench for enc2_neuron_mac. Two instances share all inputs: one
// built with ReLU, one without, so signed results are visible on the second.
module tb_enc2_neuron_mac;

  localparam int DW = 16;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*DW-1:0] weights;
  logic [DW-1:0] bias;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          out_ready;

  logic          ra_ready, rb_ready;
  logic [DW-1:0] ra_data, rb_data;
  logic          ra_valid, rb_valid;

  logic [DW-1:0] w_vec [N];
  logic [DW-1:0] x_vec [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) weights[i*DW +: DW] = w_vec[i];
  end

  enc2_neuron_mac #(.DATA_WIDTH(16), .FRAC_BITS(8), .N_IN(16), .ACC_WIDTH(40), .RELU(1'b1)) dut (
    .clk(clk), .rst(rst), .weights(weights), .bias(bias),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ra_ready),
    .out_data(ra_data), .out_valid(ra_valid), .out_ready(out_ready)
  );

  enc2_neuron_mac #(.DATA_WIDTH(16), .FRAC_BITS(8), .N_IN(16), .ACC_WIDTH(40), .RELU(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .weights(weights), .bias(bias),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rb_ready),
    .out_data(rb_data), .out_valid(rb_valid), .out_ready(out_ready)
  );

  task automatic fill_w(input logic [DW-1:0] v);
    for (int i = 0; i < N; i++) w_vec[i] = v;
  endtask

  task automatic fill_x(input logic [DW-1:0] v);
    for (int i = 0; i < N; i++) x_vec[i] = v;
  endtask

  // Called at a negedge; returns at the negedge following the last accepted beat.
  task automatic feed_vec(input int gap_max, input int n_beats, output bit to);
    int guard;
    int g;
    to = 1'b0;
    for (int i = 0; i < n_beats; i++) begin
      if (gap_max > 0) begin
        g = int'($urandom_range(gap_max, 0));
        in_valid = 1'b0;
        for (int k = 0; k < g; k++) begin
          in_data = DW'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = x_vec[i];
      guard = 0;
      while (!ra_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) to = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Counts negedges from the one right after the last beat until out_valid.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!ra_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; bias = '0;
    fill_w(16'h0100); fill_x(16'h0000);
    #12;
    @(negedge clk);
    checks++; if (ra_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", ra_ready); end
    checks++; if (ra_valid !== 1'b0 || rb_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b/%b exp=0", ra_valid, rb_valid); end
    checks++; if (ra_data !== 16'h0000 || rb_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h/%h exp=0000", ra_data, rb_data); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ra_ready !== 1'b1 || rb_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b/%b exp=1", ra_ready, rb_ready); end
  endtask

  task automatic test_identity();
    bit to; int lat;
    fill_w(16'h0100); fill_x(16'h0100); bias = 16'h0000;
    feed_vec(0, N, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL identity_feed_timeout got=%b exp=0", to); end
    checks++; if (ra_valid !== 1'b0 || ra_ready !== 1'b0) begin failures++; $display("FAIL identity_final_cycle valid=%b ready=%b exp=0/0", ra_valid, ra_ready); end
    wait_result(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL identity_latency got=%0d exp=2", lat); end
    checks++; if (ra_data !== 16'h1000 || rb_data !== 16'h1000) begin failures++; $display("FAIL identity_data got=%h/%h exp=1000", ra_data, rb_data); end
    take_output();
    checks++; if (ra_valid !== 1'b0 || ra_ready !== 1'b1) begin failures++; $display("FAIL identity_after_hs valid=%b ready=%b exp=0/1", ra_valid, ra_ready); end
  endtask

  task automatic test_bias_only();
    bit to; int lat;
    fill_w(16'h0100); fill_x(16'h0000); bias = 16'hFFCD;
    feed_vec(0, N, to);
    wait_result(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL bias_latency got=%0d exp=2", lat); end
    checks++; if (ra_data !== 16'h0000) begin failures++; $display("FAIL bias_relu got=%h exp=0000", ra_data); end
    checks++; if (rb_data !== 16'hFFCD) begin failures++; $display("FAIL bias_norelu got=%h exp=ffcd", rb_data); end
    take_output();
  endtask

  task automatic test_saturation();
    bit to; int lat;
    fill_w(16'h7FFF); fill_x(16'h7FFF); bias = 16'h0000;
    feed_vec(0, N, to);
    wait_result(lat);
    checks++; if (ra_data !== 16'h7FFF || rb_data !== 16'h7FFF) begin failures++; $display("FAIL sat_pos got=%h/%h exp=7fff", ra_data, rb_data); end
    take_output();
    fill_x(16'h8000);
    feed_vec(0, N, to);
    wait_result(lat);
    checks++; if (rb_data !== 16'h8000) begin failures++; $display("FAIL sat_neg_norelu got=%h exp=8000", rb_data); end
    checks++; if (ra_data !== 16'h0000) begin failures++; $display("FAIL sat_neg_relu got=%h exp=0000", ra_data); end
    take_output();
  endtask

  task automatic test_rounding();
    bit to; int lat;
    fill_w(16'h0100); fill_x(16'h0000); bias = 16'h0000;
    x_vec[0] = 16'h0001; w_vec[0] = 16'h0080;
    feed_vec(0, N, to);
    wait_result(lat);
    checks++; if (ra_data !== 16'h0001 || rb_data !== 16'h0001) begin failures++; $display("FAIL round_half_up got=%h/%h exp=0001", ra_data, rb_data); end
    take_output();
    w_vec[0] = 16'h007F;
    feed_vec(0, N, to);
    wait_result(lat);
    checks++; if (ra_data !== 16'h0000 || rb_data !== 16'h0000) begin failures++; $display("FAIL round_below_half got=%h/%h exp=0000", ra_data, rb_data); end
    take_output();
  endtask

  // Only weight 3 is nonzero (2.0); inputs are 0.0,1.0,...,15.0 -> 6.0.
  task automatic test_weight_select();
    bit to; int lat;
    fill_w(16'h0000); w_vec[3] = 16'h0200; bias = 16'h0000;
    for (int i = 0; i < N; i++) x_vec[i] = DW'(i * 256);
    feed_vec(0, N, to);
    wait_result(lat);
    checks++; if (ra_data !== 16'h0600 || rb_data !== 16'h0600) begin failures++; $display("FAIL weight_select got=%h/%h exp=0600", ra_data, rb_data); end
    take_output();
  endtask

  // Weights alternate +1/-1, inputs 0.5: products cancel, bias 1.0 remains.
  task automatic test_backpressure();
    bit to; int lat;
    for (int i = 0; i < N; i++) w_vec[i] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
    fill_x(16'h0080); bias = 16'h0100;
    feed_vec(3, N, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL bp_feed_timeout got=%b exp=0", to); end
    wait_result(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL bp_latency got=%0d exp=2", lat); end
    in_valid = 1'b1; in_data = 16'h7FFF;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ra_data !== 16'h0100 || rb_data !== 16'h0100 || ra_valid !== 1'b1 || ra_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d data=%h/%h valid=%b ready=%b exp=0100/0100 1 0", c, ra_data, rb_data, ra_valid, ra_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    take_output();
    checks++; if (ra_valid !== 1'b0 || ra_ready !== 1'b1) begin failures++; $display("FAIL bp_after_hs valid=%b ready=%b exp=0/1", ra_valid, ra_ready); end
  endtask

  task automatic test_back_to_back();
    bit to; int lat;
    fill_w(16'h0100); fill_x(16'h0100); bias = 16'h0000;
    x_vec[5] = 16'h0200;
    feed_vec(2, N, to);
    wait_result(lat);
    checks++; if (ra_data !== 16'h1100 || rb_data !== 16'h1100) begin failures++; $display("FAIL b2b_data got=%h/%h exp=1100", ra_data, rb_data); end
    take_output();
  endtask

  task automatic test_reset_mid();
    bit to; int lat;
    fill_w(16'h0100); fill_x(16'h0100); bias = 16'h0000;
    feed_vec(0, N, to);
    wait_result(lat);
    rst = 1'b1;
    #1;
    checks++; if (ra_valid !== 1'b0 || rb_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b/%b exp=0", ra_valid, rb_valid); end
    checks++; if (ra_data !== 16'h0000 || rb_data !== 16'h0000) begin failures++; $display("FAIL rst_out_data got=%h/%h exp=0000", ra_data, rb_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_x(16'h7FFF);
    feed_vec(0, 7, to);
    rst = 1'b1;
    #1;
    checks++; if (ra_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", ra_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_x(16'h0100);
    feed_vec(0, N, to);
    wait_result(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rst_mid_latency got=%0d exp=2", lat); end
    checks++; if (ra_data !== 16'h1000 || rb_data !== 16'h1000) begin failures++; $display("FAIL rst_mid_data got=%h/%h exp=1000", ra_data, rb_data); end
    take_output();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_identity();
    test_bias_only();
    test_saturation();
    test_rounding();
    test_weight_select();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
